// File: rtl/regfile_write_arbiter.sv
// Two-channel writeback arbiter for the register file's single write port,
// with same-address ordering, x0 filtering, starvation guard and pending scoreboard.
module regfile_write_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_addr,
    input  logic [31:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_addr,
    input  logic [31:0] req1_data,
    output logic        wr_ena,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic [31:0] pending,
    output logic        starve_boost
);

    logic             hv0, hv1;
    logic [4:0]       haddr0, haddr1;
    logic [31:0]      hdata0, hdata1;
    logic             older1;
    logic [CNT_W-1:0] starve_cnt;
    logic             grant0, grant1;
    logic             fill0, fill1;

    assign starve_boost = (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Same-address conflicts follow fill order; otherwise the guard decides.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (hv0 && hv1) begin
            if (haddr0 == haddr1) begin
                grant1 = older1;
                grant0 = !older1;
            end else begin
                grant1 = starve_boost;
                grant0 = !starve_boost;
            end
        end else begin
            grant0 = hv0;
            grant1 = hv1;
        end
    end

    assign req0_ready = !hv0 || grant0;
    assign req1_ready = !hv1 || grant1;
    assign fill0      = req0_valid && req0_ready && (req0_addr != 5'd0);
    assign fill1      = req1_valid && req1_ready && (req1_addr != 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ena  <= 1'b0;
            wr_addr <= 5'd0;
            wr_data <= 32'd0;
        end else if (grant0) begin
            wr_ena  <= 1'b1;
            wr_addr <= haddr0;
            wr_data <= hdata0;
        end else if (grant1) begin
            wr_ena  <= 1'b1;
            wr_addr <= haddr1;
            wr_data <= hdata1;
        end else begin
            wr_ena  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hv0    <= 1'b0;
            haddr0 <= 5'd0;
            hdata0 <= 32'd0;
            hv1    <= 1'b0;
            haddr1 <= 5'd0;
            hdata1 <= 32'd0;
            older1 <= 1'b0;
        end else begin
            if (fill0) begin
                hv0    <= 1'b1;
                haddr0 <= req0_addr;
                hdata0 <= req0_data;
            end else if (grant0) begin
                hv0    <= 1'b0;
            end
            if (fill1) begin
                hv1    <= 1'b1;
                haddr1 <= req1_addr;
                hdata1 <= req1_data;
            end else if (grant1) begin
                hv1    <= 1'b0;
            end
            // A channel 0 fill leaves channel 1 as the older entry, including simultaneous fills.
            if (fill0) begin
                older1 <= 1'b1;
            end else if (fill1) begin
                older1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (!hv1 || grant1) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_comb begin
        pending = 32'd0;
        if (hv0) begin
            pending = pending | (32'd1 << haddr0);
        end
        if (hv1) begin
            pending = pending | (32'd1 << haddr1);
        end
        if (wr_ena) begin
            pending = pending | (32'd1 << wr_addr);
        end
        pending[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against a
// timestamp-based reference model of the two request slots.
module tb_regfile_write_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        wr_ena;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] pending;
    logic        starve_boost;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_addr    (req0_addr),
        .req0_data    (req0_data),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_addr    (req1_addr),
        .req1_data    (req1_data),
        .wr_ena       (wr_ena),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .pending      (pending),
        .starve_boost (starve_boost)
    );

    // Reference model: each slot remembers the cycle it was filled in.
    typedef struct {
        bit          v;
        logic [4:0]  a;
        logic [31:0] d;
        int          stamp;
    } slot_t;

    slot_t       ms[2];
    int          m_wait;
    int          m_cyc;
    bit          m_wena;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ms[i] = '{1'b0, 5'd0, 32'd0, 0};
        end
        m_wait  = 0;
        m_wena  = 1'b0;
        m_waddr = 5'd0;
        m_wdata = 32'd0;
    endtask

    function automatic int model_grant();
        if (ms[0].v && ms[1].v) begin
            if (ms[0].a == ms[1].a) begin
                return (ms[1].stamp <= ms[0].stamp) ? 1 : 0;
            end
            return (m_wait >= LIMIT) ? 1 : 0;
        end
        if (ms[0].v) return 0;
        if (ms[1].v) return 1;
        return -1;
    endfunction

    function automatic logic [31:0] model_pending();
        logic [31:0] p = 32'd0;
        for (int r = 1; r < 32; r++) begin
            if ((ms[0].v && ms[0].a == 5'(r)) || (ms[1].v && ms[1].a == 5'(r)) ||
                (m_wena && m_waddr == 5'(r))) begin
                p[r] = 1'b1;
            end
        end
        return p;
    endfunction

    // One cycle: drive at negedge, compare against the model, then advance the model past the posedge.
    task automatic apply_stimulus(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                                  input bit v1, input logic [4:0] a1, input logic [31:0] d1);
        int g;
        bit acc0, acc1;
        @(negedge clk);
        req0_valid = v0;
        req0_addr  = a0;
        req0_data  = d0;
        req1_valid = v1;
        req1_addr  = a1;
        req1_data  = d1;
        #1;
        g = model_grant();
        check_output("req0_ready", 32'(req0_ready), 32'(!ms[0].v || g == 0));
        check_output("req1_ready", 32'(req1_ready), 32'(!ms[1].v || g == 1));
        check_output("wr_ena", 32'(wr_ena), 32'(m_wena));
        check_output("wr_addr", 32'(wr_addr), 32'(m_waddr));
        check_output("wr_data", wr_data, m_wdata);
        check_output("pending", pending, model_pending());
        check_output("starve_boost", 32'(starve_boost), 32'(m_wait == LIMIT));
        acc0 = v0 && (!ms[0].v || g == 0);
        acc1 = v1 && (!ms[1].v || g == 1);
        if (!ms[1].v || g == 1) begin
            m_wait = 0;
        end else if (m_wait < LIMIT) begin
            m_wait++;
        end
        if (g >= 0) begin
            m_wena  = 1'b1;
            m_waddr = ms[g].a;
            m_wdata = ms[g].d;
            ms[g].v = 1'b0;
        end else begin
            m_wena = 1'b0;
        end
        if (acc0 && a0 != 5'd0) ms[0] = '{1'b1, a0, d0, m_cyc};
        if (acc1 && a1 != 5'd0) ms[1] = '{1'b1, a1, d1, m_cyc};
        m_cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        end
    endtask

    // Pulse reset between clock edges and confirm everything clears without a clock.
    task automatic do_reset(input string tag);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_output({tag, "_wr_ena"}, 32'(wr_ena), 32'd0);
        check_output({tag, "_pending"}, pending, 32'd0);
        check_output({tag, "_ready0"}, 32'(req0_ready), 32'd1);
        check_output({tag, "_ready1"}, 32'(req1_ready), 32'd1);
        check_output({tag, "_boost"}, 32'(starve_boost), 32'd0);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        rst        = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_addr  = 5'd0;
        req1_addr  = 5'd0;
        req0_data  = 32'd0;
        req1_data  = 32'd0;
        m_cyc      = 0;
        model_reset();

        repeat (2) @(negedge clk);
        #1;
        check_output("rst_wr_ena", 32'(wr_ena), 32'd0);
        check_output("rst_wr_addr", 32'(wr_addr), 32'd0);
        check_output("rst_wr_data", wr_data, 32'd0);
        check_output("rst_pending", pending, 32'd0);
        check_output("rst_boost", 32'(starve_boost), 32'd0);
        check_output("rst_ready0", 32'(req0_ready), 32'd1);
        check_output("rst_ready1", 32'(req1_ready), 32'd1);
        rst = 1'b1;
        idle(2);

        // Single write, visible on the port two edges after acceptance.
        apply_stimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            check_output("single_pending5", 32'(pending[5]), 32'(k <= 2));
            check_output("single_wr_ena", 32'(wr_ena), 32'(k == 2));
            if (k == 2) begin
                check_output("single_wr_addr", 32'(wr_addr), 32'd5);
                check_output("single_wr_data", wr_data, 32'hDEADBEEF);
            end
        end

        // x0 write is consumed but leaves no trace.
        apply_stimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);
        check_output("x0_ready1", 32'(req1_ready), 32'd1);
        for (int k = 0; k < 2; k++) begin
            apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            check_output("x0_wr_ena", 32'(wr_ena), 32'd0);
            check_output("x0_pending", pending, 32'd0);
        end
        idle(2);

        // Channel 0 streams while channel 1 waits on addr 9.
        for (int k = 0; k < 9; k++) begin
            apply_stimulus(1'b1, 5'(k % 8 + 1), $urandom, k == 0, 5'd9, 32'h0000_0009);
            if (k >= 1) begin
                check_output("starve_boost_seq", 32'(starve_boost), 32'(k == 5));
                check_output("starve_ch1_write", 32'(wr_ena && wr_addr == 5'd9), 32'(k == 6));
            end
        end
        idle(4);

        // Same-cycle same-address: channel 1 first, channel 0 lands last.
        apply_stimulus(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
        for (int k = 1; k <= 4; k++) begin
            apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            check_output("same_pending7", 32'(pending[7]), 32'(k <= 3));
            if (k == 2) check_output("same_first", wr_data, 32'hB);
            if (k == 3) check_output("same_last", wr_data, 32'hA);
        end

        // Channel 1 accepted one cycle earlier on the same address.
        apply_stimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hB);
        apply_stimulus(1'b1, 5'd7, 32'hA, 1'b0, 5'd0, 32'd0);
        for (int k = 2; k <= 3; k++) begin
            apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            check_output("early1_wr_ena", 32'(wr_ena), 32'd1);
            check_output("early1_wr_data", wr_data, (k == 2) ? 32'hB : 32'hA);
        end
        idle(2);

        // Async reset with both slots full and a write on the port.
        apply_stimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
        apply_stimulus(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0);
        apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check_output("pre_reset_wr_ena", 32'(wr_ena), 32'd1);
        check_output("pre_reset_pending", pending, 32'h0000_0058);
        do_reset("async");
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            check_output("post_reset_wr_ena", 32'(wr_ena), 32'd0);
        end

        // Random traffic biased toward a few addresses to provoke conflicts.
        for (int c = 0; c < 1500; c++) begin
            apply_stimulus($urandom_range(0, 9) < 6,
                           ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
                           $urandom,
                           $urandom_range(0, 9) < 6,
                           ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
                           $urandom);
            if (c % 500 == 499) do_reset("rand_reset");
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters.
  - Channel 0: ALU writeback, normal high priority.
  - Channel 1: load-unit writeback, low priority with a starvation guard.
- Buffers one request per channel, enforces same-address write ordering, drops x0 writes, and drives registered wr_ena/wr_addr/wr_data into the register file.
- Exports a pending-write scoreboard for hazard detection in the issue logic.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles channel 1 may wait while holding a request before it gets priority (legal range 1..15).
- CNT_W, 4: width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- req0_valid  in  1  channel 0 request valid
- req0_ready  out  1  channel 0 may accept this cycle
- req0_addr  in  5  channel 0 destination register
- req0_data  in  32  channel 0 write data
- req1_valid  in  1  channel 1 request valid
- req1_ready  out  1  channel 1 may accept this cycle
- req1_addr  in  5  channel 1 destination register
- req1_data  in  32  channel 1 write data
- wr_ena  out  1  register file write enable (registered)
- wr_addr  out  5  register file write address (registered)
- wr_data  out  32  register file write data (registered)
- pending  out  32  bit r = 1 while a write to xr is buffered or on the write port
- starve_boost  out  1  channel 1 currently holds priority via the starvation guard

Behaviour:
- Reset (rst=0, async): both slots empty, age bit 0, counter 0, wr_ena=0, wr_addr=0, wr_data=0, pending=0, starve_boost=0.
- Per-channel slot: hv_i, haddr_i, hdata_i.
  - reqi_ready = !hv_i | grant_i, combinational.
  - Accept occurs when reqi_valid & reqi_ready at a posedge.
- x0 filter: an accepted request with addr==0 is consumed and discarded. The slot does not fill and pending is unaffected.
- Grant, combinational, at most one per cycle:
  - Only one slot full: that slot is granted.
  - Both full, haddr0==haddr1: the older slot is granted. Same-cycle acceptance counts channel 1 as older, so channel 0's value lands last.
  - Both full, different addresses: channel 1 is granted if starve_boost, else channel 0.
- Age bit: records which slot was filled first, updated on every fill.
- Output stage, on posedge:
  - With a grant: wr_ena<=1, wr_addr/wr_data <= the granted slot's contents, and that slot empties unless refilled in the same cycle.
  - Without a grant: wr_ena<=0, wr_addr/wr_data hold.
- Latency: accept at edge E0, output register loaded at E1, register file commits at E2. Minimum is 2 cycles from valid to committed.
- Throughput: 1 write per cycle sustained. A slot can drain and refill on the same edge.
- Starvation counter:
  - Increments each cycle hv1 & !grant1, saturating at STARVE_LIMIT.
  - Clears on grant1 or when hv1=0.
  - starve_boost = (counter == STARVE_LIMIT).
- Scoreboard: pending = onehot(haddr0)&hv0 | onehot(haddr1)&hv1 | onehot(wr_addr)&wr_ena. Bit 0 is always 0.
- Reset mid-operation: all buffered and in-flight writes are discarded and wr_ena drops immediately (async). Requesters must reissue.
- Ready is never gated by the other channel's valid, so there are no combinational valid-to-ready loops across channels.

Test Plan:
- Reset then idle → all outputs 0, req0_ready=req1_ready=1.
- Single write: req0 {addr=5, data=0xDEADBEEF} for one cycle → wr_ena=1, wr_addr=5, wr_data=0xDEADBEEF two edges later; pending[5]=1 for exactly 2 cycles.
- x0 drop: req1 {addr=0, data=0x1234} → accepted (ready=1), wr_ena stays 0, pending stays 0.
- Contention with starvation: req0 streams addr 1..8 every cycle while req1 holds addr=9.
  - Channel 1 is granted after exactly 4 waiting cycles.
  - starve_boost=1 for that one cycle, then the counter returns to 0.
- Same-address ordering:
  - Same cycle: req0 {addr=7, data=0xA} and req1 {addr=7, data=0xB} → channel 1 written first, 0xA written last; pending[7] stays 1 until the final write.
  - Req1 accepted one cycle earlier, both addr=7 → channel 1 still granted first.
- Async reset with both slots full and wr_ena=1 → wr_ena, pending and both slots clear without a clock edge; no write is issued after release.
